// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] data;
  } fetch_entry_t;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: redirect input, imem request/response channel, decode channel.
// Handshakes: a transfer happens on a rising edge where valid && ready; the sender keeps payload stable while valid && !ready. imem responses have no ready and are always accepted.
interface instr_fetch_unit_if import fetch_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              busy;
  fetch_state_t      dbg_state;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, busy, dbg_state
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, busy, dbg_state
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of packed {pc, data} entries with synchronous flush; DEPTH is a power of 2.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher: credit-limited imem requests, in-order responses
// into a prefetch FIFO, redirect flush with discard of in-flight responses.
module instr_fetch_unit import fetch_pkg::*; #(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  localparam int                CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]    CAP   = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN = ADDR_W'(INST_BYTES - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic              started_q, started_d;

  logic                     req_valid, req_fire, fifo_push, fifo_pop;
  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_full, fifo_empty;
  logic [ADDR_W+DATA_W-1:0] fifo_rdata;
  logic [ADDR_W-1:0]        redirect_target;

  // started_q holds requests off for the first cycle after any reset edge.
  assign req_valid = started_q && (state_q == ST_FETCH) && !bus.redirect_valid &&
                     (({1'b0, out_q} + {1'b0, fifo_count}) < CAP);
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign fifo_push = bus.imem_rsp_valid && !bus.redirect_valid && (discard_q == '0) && !fifo_full;
  assign fifo_pop  = !fifo_empty && bus.inst_ready;
  assign redirect_target = bus.redirect_pc & ~ALIGN;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    discard_d  = discard_q;
    started_d  = 1'b1;
    out_d      = out_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
    if (bus.redirect_valid) begin
      // Every response still owed after this edge belongs to the old stream.
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      discard_d  = out_q - CNT_W'(bus.imem_rsp_valid);
      state_d    = (discard_d != '0) ? ST_DRAIN : ST_FETCH;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end
      if (fifo_push) begin
        rsp_pc_d = rsp_pc_q + STEP;
      end
      if (bus.imem_rsp_valid && (discard_q != '0)) begin
        discard_d = discard_q - 1'b1;
      end
      if ((state_q == ST_DRAIN) && (discard_d == '0)) begin
        state_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      discard_q  <= '0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
      started_q  <= started_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.redirect_valid),
    .push  (fifo_push),
    .wdata ({rsp_pc_q, bus.imem_rsp_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = !fifo_empty;
  assign bus.inst_pc        = fifo_rdata[ADDR_W+DATA_W-1:DATA_W];
  assign bus.inst_data      = fifo_rdata[DATA_W-1:0];
  assign bus.busy           = (state_q == ST_DRAIN);
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table plus hand-written redirect/reset sequences.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory model: fixed-latency, in-order responses with data = addr ^ MAGIC.
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mem_req_t;

  mem_req_t    mem_q[$];
  logic [31:0] exp_q[$];
  logic        mem_en = 1'b0;
  int unsigned mem_lat = 1;
  int unsigned cyc = 0;
  logic        mem_rsp_v = 1'b0;
  logic [31:0] mem_rsp_d = '0;
  logic        tbl_rsp_v = 1'b0;
  logic [31:0] tbl_rsp_d = '0;

  assign bus.imem_rsp_valid = mem_en ? mem_rsp_v : tbl_rsp_v;
  assign bus.imem_rsp_data  = mem_en ? mem_rsp_d : tbl_rsp_d;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      mem_rsp_v = 1'b0;
      mem_rsp_d = '0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        mem_rsp_v = 1'b1;
        mem_rsp_d = mem_q[0].addr ^ MAGIC;
        void'(mem_q.pop_front());
      end
      @(negedge clk);
      if (!rst_n) begin
        mem_q.delete();
      end else if (mem_en && bus.imem_req_valid && bus.imem_req_ready) begin
        mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + mem_lat});
      end
    end
  end

  typedef struct {
    logic        rst_n;
    logic        redir;
    logic [31:0] redir_pc;
    logic        req_ready;
    logic        rsp_v;
    logic [31:0] rsp_addr;
    logic        inst_ready;
    logic        chk;
    logic        e_req_v;
    logic [31:0] e_req_addr;
    logic        e_inst_v;
    logic [31:0] e_inst_pc;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rd, input logic [31:0] rpc, input logic rq_rdy,
                     input logic rv, input logic [31:0] ra, input logic ird, input logic c,
                     input logic erv, input logic [31:0] era, input logic eiv,
                     input logic [31:0] epc, input logic eb);
    vecs.push_back('{rst_n: r, redir: rd, redir_pc: rpc, req_ready: rq_rdy, rsp_v: rv,
                     rsp_addr: ra, inst_ready: ird, chk: c, e_req_v: erv, e_req_addr: era,
                     e_inst_v: eiv, e_inst_pc: epc, e_busy: eb});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic e_rv, input logic [31:0] e_ra,
                               input logic e_iv, input logic [31:0] e_pc, input logic e_busy);
    check({tag, " req_valid"}, 32'(bus.imem_req_valid), 32'(e_rv));
    if (e_rv) check({tag, " req_addr"}, bus.imem_req_addr, e_ra);
    check({tag, " inst_valid"}, 32'(bus.inst_valid), 32'(e_iv));
    if (e_iv) begin
      check({tag, " inst_pc"}, bus.inst_pc, e_pc);
      check({tag, " inst_data"}, bus.inst_data, e_pc ^ MAGIC);
    end
    check({tag, " busy"}, 32'(bus.busy), 32'(e_busy));
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.inst_ready = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    check_outputs("after_reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic step_check(input string tag, input logic e_rv, input logic [31:0] e_ra,
                            input logic e_iv, input logic [31:0] e_pc, input logic e_busy);
    @(negedge clk);
    check_outputs(tag, e_rv, e_ra, e_iv, e_pc, e_busy);
  endtask

  task automatic drain_expect(input string tag, input int bound);
    fetch_entry_t got;
    for (int n = 0; n < bound && exp_q.size() > 0; n++) begin
      next_cycle();
      @(negedge clk);
      if (bus.inst_valid && bus.inst_ready) begin
        got = '{pc: bus.inst_pc, data: bus.inst_data};
        check({tag, " stream_pc"}, got.pc, exp_q[0]);
        check({tag, " stream_data"}, got.data, exp_q[0] ^ MAGIC);
        void'(exp_q.pop_front());
      end
    end
    check({tag, " stream_leftover"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.inst_ready     = 1'b0;

    // rst rd rpc rdy rv raddr ird chk | erv era eiv epc busy
    add(0, 0, 0, 0, 0, 32'h00, 0, 0,   0, 32'h00, 0, 32'h00, 0);
    add(0, 0, 0, 0, 0, 32'h00, 0, 1,   0, 32'h00, 0, 32'h00, 0);
    add(1, 0, 0, 1, 0, 32'h00, 0, 1,   0, 32'h00, 0, 32'h00, 0);
    add(1, 0, 0, 1, 0, 32'h00, 1, 1,   1, 32'h00, 0, 32'h00, 0);
    add(1, 0, 0, 1, 1, 32'h00, 1, 1,   1, 32'h04, 0, 32'h00, 0);
    add(1, 0, 0, 1, 1, 32'h04, 1, 1,   1, 32'h08, 1, 32'h00, 0);
    add(1, 0, 0, 1, 1, 32'h08, 1, 1,   1, 32'h0C, 1, 32'h04, 0);
    add(1, 0, 0, 1, 1, 32'h0C, 1, 1,   1, 32'h10, 1, 32'h08, 0);
    add(0, 0, 0, 1, 0, 32'h00, 0, 1,   1, 32'h14, 1, 32'h0C, 0);
    add(1, 0, 0, 1, 0, 32'h00, 0, 1,   0, 32'h00, 0, 32'h00, 0);
    add(1, 0, 0, 1, 0, 32'h00, 0, 1,   1, 32'h00, 0, 32'h00, 0);
    add(1, 0, 0, 1, 1, 32'h00, 0, 1,   1, 32'h04, 0, 32'h00, 0);
    add(1, 0, 0, 1, 1, 32'h04, 0, 1,   1, 32'h08, 1, 32'h00, 0);
    add(1, 0, 0, 1, 1, 32'h08, 0, 1,   1, 32'h0C, 1, 32'h00, 0);
    add(1, 0, 0, 1, 1, 32'h0C, 0, 1,   0, 32'h00, 1, 32'h00, 0);
    add(1, 0, 0, 1, 0, 32'h00, 1, 1,   0, 32'h00, 1, 32'h00, 0);
    add(1, 0, 0, 1, 0, 32'h00, 1, 1,   1, 32'h10, 1, 32'h04, 0);
    add(1, 0, 0, 0, 0, 32'h00, 1, 1,   1, 32'h14, 1, 32'h08, 0);
    add(1, 0, 0, 0, 1, 32'h10, 1, 1,   1, 32'h14, 1, 32'h0C, 0);
    add(1, 0, 0, 0, 0, 32'h00, 1, 1,   1, 32'h14, 1, 32'h10, 0);
    add(1, 0, 0, 0, 0, 32'h00, 0, 1,   1, 32'h14, 0, 32'h00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      next_cycle();
      rst_n              = vecs[i].rst_n;
      bus.redirect_valid = vecs[i].redir;
      bus.redirect_pc    = vecs[i].redir_pc;
      bus.imem_req_ready = vecs[i].req_ready;
      bus.inst_ready     = vecs[i].inst_ready;
      tbl_rsp_v          = vecs[i].rsp_v;
      tbl_rsp_d          = vecs[i].rsp_addr ^ MAGIC;
      @(negedge clk);
      if (vecs[i].chk) begin
        check_outputs($sformatf("vec%0d", i), vecs[i].e_req_v, vecs[i].e_req_addr,
                      vecs[i].e_inst_v, vecs[i].e_inst_pc, vecs[i].e_busy);
      end
    end
    next_cycle();
    tbl_rsp_v = 1'b0;
    mem_en = 1'b1;

    // Redirect with three requests in flight and no response that cycle.
    do_reset();
    mem_lat = 4;
    next_cycle(); bus.inst_ready = 1'b1;
    step_check("dr c1", 1, 32'h0, 0, 32'h0, 0);
    next_cycle(); step_check("dr c2", 1, 32'h4, 0, 32'h0, 0);
    next_cycle(); step_check("dr c3", 1, 32'h8, 0, 32'h0, 0);
    next_cycle(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0103;
    step_check("dr c4", 0, 32'h0, 0, 32'h0, 0);
    next_cycle(); bus.redirect_valid = 1'b0;
    step_check("dr c5", 0, 32'h0, 0, 32'h0, 1);
    check("dr dbg_state", 32'(bus.dbg_state), 32'(ST_DRAIN));
    next_cycle(); step_check("dr c6", 0, 32'h0, 0, 32'h0, 1);
    next_cycle(); step_check("dr c7", 0, 32'h0, 0, 32'h0, 1);
    next_cycle(); step_check("dr c8", 1, 32'h100, 0, 32'h0, 0);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    drain_expect("dr", 20);

    // Redirect coinciding with a response and a decode handshake, then address wrap.
    do_reset();
    mem_lat = 2;
    next_cycle(); bus.inst_ready = 1'b1;
    step_check("rr c1", 1, 32'h0, 0, 32'h0, 0);
    next_cycle(); step_check("rr c2", 1, 32'h4, 0, 32'h0, 0);
    next_cycle(); step_check("rr c3", 1, 32'h8, 0, 32'h0, 0);
    next_cycle(); step_check("rr c4", 1, 32'hC, 1, 32'h0, 0);
    next_cycle(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFA;
    step_check("rr c5", 0, 32'h0, 1, 32'h4, 0);
    next_cycle(); bus.redirect_valid = 1'b0;
    step_check("rr c6", 0, 32'h0, 0, 32'h0, 1);
    next_cycle(); step_check("rr c7", 1, 32'hFFFF_FFF8, 0, 32'h0, 0);
    next_cycle(); step_check("rr c8", 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
    next_cycle(); step_check("rr c9", 1, 32'h0000_0000, 0, 32'h0, 0);
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    drain_expect("rr", 20);

    // Reset with two buffered and two outstanding fetches.
    do_reset();
    mem_lat = 2;
    next_cycle(); step_check("rs c1", 1, 32'h0, 0, 32'h0, 0);
    next_cycle(); step_check("rs c2", 1, 32'h4, 0, 32'h0, 0);
    next_cycle(); step_check("rs c3", 1, 32'h8, 0, 32'h0, 0);
    next_cycle(); step_check("rs c4", 1, 32'hC, 1, 32'h0, 0);
    next_cycle(); rst_n = 1'b0;
    step_check("rs c5", 0, 32'h0, 1, 32'h0, 0);
    next_cycle(); rst_n = 1'b1;
    step_check("rs c6", 0, 32'h0, 0, 32'h0, 0);
    next_cycle(); bus.inst_ready = 1'b1;
    step_check("rs c7", 1, 32'h0, 0, 32'h0, 0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    drain_expect("rs", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch-side consumer of program-counter addresses. Generates sequential word-aligned fetch addresses, issues them to instruction memory over a valid/ready request channel, and collects in-order responses into a prefetch FIFO. Presents instruction+PC pairs to decode over valid/ready. Branch redirect flushes the FIFO and discards in-flight responses.

Parameters:
ADDR_W, 32, fetch address width
DATA_W, 32, instruction width
DEPTH, 4, prefetch FIFO entries; also the cap on outstanding plus buffered fetches (power of 2, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  ADDR_W  new fetch address; bits [1:0] ignored, forced to 0
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_W  fetch address
imem_rsp_valid  input  1  response valid; in order; no backpressure
imem_rsp_data  input  DATA_W  instruction word
inst_valid  output  1  FIFO head valid
inst_ready  input  1  decode accepts head
inst_data  output  DATA_W  head instruction
inst_pc  output  ADDR_W  head instruction address
busy  output  1  high in DRAIN state

Behaviour:
- Reset (rst_n=0 at edge): fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard_cnt=0, state=FETCH; imem_req_valid=0, inst_valid=0, busy=0 for the cycle after reset.
- Internal counters: outstanding (accepted requests without response, 0..DEPTH); count (FIFO occupancy, 0..DEPTH); discard_cnt (0..DEPTH).
- Credit rule: imem_req_valid = (state==FETCH) && (outstanding+count < DEPTH) && !redirect_valid. Response therefore never finds FIFO full. Combinational from registered state plus redirect_valid.
- imem_req_addr = fetch_pc. Request handshake: fetch_pc += 4 (mod 2^ADDR_W; 0xFFFF_FFFC wraps to 0), outstanding++. Addr stable while valid and not ready.
- PC tracking: a second register req_pc_q FIFO (DEPTH deep, or pc carried in main FIFO) tags each response with the issuing address; response PCs are strictly sequential from last redirect, so a separate rsp_pc register (+4 per accepted non-discarded response) suffices.
- Response, discard_cnt==0: push {rsp_pc, data}, outstanding--. Response, discard_cnt>0: drop, discard_cnt--, outstanding--.
- Decode handshake inst_valid&&inst_ready: pop head, count--. Valid same cycle as redirect (transfer counts).
- Push and pop same cycle: count unchanged; data ordering preserved. Push into empty FIFO visible on inst_valid next cycle (1-cycle response-to-decode latency).
- States: FETCH, DRAIN.
  FETCH -> DRAIN on redirect_valid when in-flight responses remain after this cycle's edge (outstanding, plus this cycle's accepted... none since req suppressed, minus this cycle's response) > 0; else stay FETCH.
  DRAIN -> FETCH when discard_cnt reaches 0 (including last discarded response this cycle). No requests in DRAIN.
- Redirect (any state) at edge: FIFO cleared (head popped this cycle still delivered), fetch_pc=rsp_pc={redirect_pc[ADDR_W-1:2],2'b00}, discard_cnt = outstanding - (imem_rsp_valid?1:0). Redirect during DRAIN reloads same way.
- Redirect and response same cycle: response dropped.
- Reset mid-operation: all state cleared; memory side assumed reset simultaneously (no stale responses).
- busy = (state==DRAIN).

Decomposition:
- Shared package fetch_pkg: ADDR_W/DATA_W defaults, INST_BYTES=4, fetch_entry_t {pc, data}, state enum {FETCH, DRAIN}.
- One sub-module: fetch_fifo (parameterised DEPTH, synchronous flush, push/pop/count, full/empty); FSM, counters, credit logic in instr_fetch_unit.

Test Plan:
- Reset, imem_req_ready=1, memory responds 1 cycle later with data=addr^32'hA5A5_0000, inst_ready=1 -> requests 0x0,0x4,0x8...; inst_pc 0x0,0x4,0x8 with matching data, one per cycle after fill.
- inst_ready=0, memory always ready -> exactly 4 requests issued (0x0..0xC), then imem_req_valid=0; raise inst_ready -> 4 instructions in order, fetching resumes at 0x10.
- Memory latency 3 cycles, 3 outstanding; redirect_valid with redirect_pc=0x103 -> busy=1, 3 responses dropped, next request addr 0x100, first inst_pc=0x100.
- Redirect same cycle as a response and as inst handshake -> handshaked instruction delivered once; that response dropped; discard_cnt = outstanding-1.
- redirect_pc=0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst_n=0 while FIFO holds 2 and 2 outstanding -> next cycle inst_valid=0, imem_req_valid=0, busy=0; then fetching restarts at RESET_PC.
